inst_mem_sync: RTL and testbench

INST_MEM_SYNC -- requirements
Module: inst_mem_sync

---
 rtl/inst_mem_sync.sv | 143 ++++++++++++++
 tb/tb_inst_mem_sync.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_mem_sync.sv
// inst_mem_sync: instruction memory with a RUN/LOAD mode machine.
// Ports:
//   clk, reset        : clock and synchronous active-high reset
//   fetch_*           : registered 1-cycle fetch (req, byte addr, stall)
//   instruction       : fetched word, NOP_WORD on fault
//   fetch_valid/fault : status of the word in instruction
//   load_*            : sequential program load (start, we, data, done)
//   loading           : high while in LOAD
//   load_count        : words written in current or last load
//   load_overflow     : sticky, a write was dropped at full depth
module inst_mem_sync #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_WORD = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [31:0]           fetch_addr,
    input  logic                  fetch_stall,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic                  fetch_valid,
    output logic                  fetch_fault,
    input  logic                  load_start,
    input  logic                  load_we,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_done,
    output logic                  loading,
    output logic [ADDR_WIDTH:0]   load_count,
    output logic                  load_overflow
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        S_RUN,
        S_LOAD
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH:0]     ptr_q, ptr_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;
    logic                    fault_q, fault_d;
    logic [DATA_WIDTH-1:0]   instr_q, instr_d;
    logic                    mem_we;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [31:0]             word_off;
    logic [ADDR_WIDTH-1:0]   idx;
    logic                    fetch_bad;

    // Word offset from the base; a below-base address wraps to a huge
    // value, but it is also rejected explicitly.
    assign word_off  = (fetch_addr - BASE_ADDR) >> 2;
    assign idx       = word_off[ADDR_WIDTH-1:0];
    assign fetch_bad = (fetch_addr[1:0] != 2'b00)
                    || (fetch_addr < BASE_ADDR)
                    || ((word_off >> ADDR_WIDTH) != 32'd0);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        fault_d = fault_q;
        instr_d = instr_q;
        mem_we  = 1'b0;
        unique case (state_q)
            S_RUN: begin
                if (load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    ovf_d   = 1'b0;
                    valid_d = 1'b0;
                    fault_d = 1'b0;
                end else if (!fetch_stall) begin
                    valid_d = fetch_req;
                    fault_d = fetch_req && fetch_bad;
                    if (fetch_req) begin
                        instr_d = fetch_bad ? NOP_WORD : mem_q[idx];
                    end
                end
            end
            S_LOAD: begin
                valid_d = 1'b0;
                fault_d = 1'b0;
                if (load_start) begin
                    ptr_d = '0;
                    ovf_d = 1'b0;
                end else begin
                    if (load_we) begin
                        // Top pointer bit set means DEPTH words written.
                        if (!ptr_q[ADDR_WIDTH]) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    if (load_done) begin
                        state_d = S_RUN;
                    end
                end
            end
            default: state_d = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            instr_q <= NOP_WORD;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            fault_q <= fault_d;
            instr_q <= instr_d;
        end
    end

    // Contents are never reset; reset only blocks a concurrent write.
    always_ff @(posedge clk) begin
        if (mem_we && !reset) begin
            mem_q[ptr_q[ADDR_WIDTH-1:0]] <= load_data;
        end
    end

    assign instruction   = instr_q;
    assign fetch_valid   = valid_q;
    assign fetch_fault   = fault_q;
    assign loading       = (state_q == S_LOAD);
    assign load_count    = ptr_q;
    assign load_overflow = ovf_q;

endmodule

// File: tb/tb_inst_mem_sync.sv
// tb_inst_mem_sync: directed self-checking bench for inst_mem_sync.
// Each task drives one scenario and checks against hand-computed values.
module tb_inst_mem_sync;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic [31:0] fetch_addr = '0;
    logic        fetch_stall = 1'b0;
    logic [31:0] instruction;
    logic        fetch_valid;
    logic        fetch_fault;
    logic        load_start = 1'b0;
    logic        load_we = 1'b0;
    logic [31:0] load_data = '0;
    logic        load_done = 1'b0;
    logic        loading;
    logic [8:0]  load_count;
    logic        load_overflow;

    int errors = 0;
    int checks = 0;

    inst_mem_sync dut (
        .clk(clk), .reset(reset),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_stall(fetch_stall), .instruction(instruction),
        .fetch_valid(fetch_valid), .fetch_fault(fetch_fault),
        .load_start(load_start), .load_we(load_we),
        .load_data(load_data), .load_done(load_done),
        .loading(loading), .load_count(load_count),
        .load_overflow(load_overflow)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (instruction !== 32'h0) begin
            errors++;
            $display("FAIL rst_instr got %h exp %h", instruction, 32'h0);
        end
        checks++;
        if (fetch_valid !== 1'b0 || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL rst_flags got v%b f%b exp v0 f0",
                     fetch_valid, fetch_fault);
        end
        checks++;
        if (loading !== 1'b0 || load_count !== 9'd0
            || load_overflow !== 1'b0) begin
            errors++;
            $display("FAIL rst_load got l%b c%0d o%b exp l0 c0 o0",
                     loading, load_count, load_overflow);
        end
    endtask

    task automatic test_load_fetch();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h20040003;
        exp_w[1] = 32'h0c000003;
        exp_w[2] = 32'h1000ffff;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (loading !== 1'b1) begin
            errors++;
            $display("FAIL enter_load got %b exp 1", loading);
        end
        // Fetch during LOAD is ignored.
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        load_we = 1'b1;
        for (int i = 0; i < 3; i++) begin
            load_data = exp_w[i];
            step();
            checks++;
            if (fetch_valid !== 1'b0 || fetch_fault !== 1'b0) begin
                errors++;
                $display("FAIL load_fetch_ign got v%b f%b exp v0 f0",
                         fetch_valid, fetch_fault);
            end
        end
        fetch_req = 1'b0;
        load_we = 1'b0;
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        checks++;
        if (loading !== 1'b0 || load_count !== 9'd3) begin
            errors++;
            $display("FAIL load3 got l%b c%0d exp l0 c3",
                     loading, load_count);
        end
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = 32'(i * 4);
            step();
            checks++;
            if (instruction !== exp_w[i] || fetch_valid !== 1'b1
                || fetch_fault !== 1'b0) begin
                errors++;
                $display("FAIL b2b_%0d got %h v%b f%b exp %h v1 f0", i,
                         instruction, fetch_valid, fetch_fault, exp_w[i]);
            end
        end
        fetch_req = 1'b0;
        step();
        checks++;
        if (fetch_valid !== 1'b0 || instruction !== exp_w[2]) begin
            errors++;
            $display("FAIL idle got v%b %h exp v0 %h",
                     fetch_valid, instruction, exp_w[2]);
        end
    endtask

    task automatic test_fault();
        logic [31:0] addrs [3];
        logic        expf [3];
        addrs[0] = 32'h2;   expf[0] = 1'b1;
        addrs[1] = 32'h400; expf[1] = 1'b1;
        addrs[2] = 32'h3fc; expf[2] = 1'b0;
        fetch_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = addrs[i];
            step();
            checks++;
            if (fetch_fault !== expf[i] || fetch_valid !== 1'b1) begin
                errors++;
                $display("FAIL fault_%h got f%b v%b exp f%b v1", addrs[i],
                         fetch_fault, fetch_valid, expf[i]);
            end
            if (expf[i]) begin
                checks++;
                if (instruction !== 32'h0) begin
                    errors++;
                    $display("FAIL fault_nop got %h exp 0", instruction);
                end
            end
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_stall();
        fetch_req = 1'b1;
        fetch_addr = 32'h4;
        step();
        fetch_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch_addr = (i == 2) ? 32'h2 : 32'(8 + i * 4);
            step();
            checks++;
            if (instruction !== 32'h0c000003 || fetch_valid !== 1'b1
                || fetch_fault !== 1'b0) begin
                errors++;
                $display("FAIL stall_%0d got %h v%b f%b exp 0c000003 v1 f0",
                         i, instruction, fetch_valid, fetch_fault);
            end
        end
        fetch_stall = 1'b0;
        fetch_addr = 32'h8;
        step();
        checks++;
        if (instruction !== 32'h1000ffff || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_resume got %h v%b exp 1000ffff v1",
                     instruction, fetch_valid);
        end
        fetch_req = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_we = 1'b1;
        for (int i = 0; i < 257; i++) begin
            load_data = 32'ha500_0000 | 32'(i);
            step();
        end
        load_we = 1'b0;
        checks++;
        if (load_count !== 9'd256 || load_overflow !== 1'b1) begin
            errors++;
            $display("FAIL ovf got c%0d o%b exp c256 o1",
                     load_count, load_overflow);
        end
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        checks++;
        if (load_count !== 9'd0 || load_overflow !== 1'b0
            || loading !== 1'b1) begin
            errors++;
            $display("FAIL ovf_clr got c%0d o%b l%b exp c0 o0 l1",
                     load_count, load_overflow, loading);
        end
        load_done = 1'b1;
        step();
        load_done = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 32'h3fc;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instruction !== 32'ha500_00ff || fetch_fault !== 1'b0) begin
            errors++;
            $display("FAIL last_word got %h f%b exp a50000ff f0",
                     instruction, fetch_fault);
        end
    endtask

    task automatic test_reset_mid_load();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_we = 1'b1;
        load_data = 32'h1111_0000;
        step();
        load_data = 32'h1111_0001;
        step();
        reset = 1'b1;
        load_data = 32'hdead_beef;
        step();
        reset = 1'b0;
        load_we = 1'b0;
        checks++;
        if (loading !== 1'b0 || load_count !== 9'd0) begin
            errors++;
            $display("FAIL rst_mid got l%b c%0d exp l0 c0",
                     loading, load_count);
        end
        fetch_req = 1'b1;
        fetch_addr = 32'h4;
        step();
        fetch_addr = 32'h8;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instruction !== 32'ha500_0002) begin
            errors++;
            $display("FAIL rst_nowrite got %h exp a5000002", instruction);
        end
        fetch_req = 1'b1;
        fetch_addr = 32'h4;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instruction !== 32'h1111_0001 || fetch_valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_keep got %h v%b exp 11110001 v1",
                     instruction, fetch_valid);
        end
    endtask

    task automatic test_we_done();
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        load_we = 1'b1;
        for (int i = 0; i < 5; i++) begin
            load_data = 32'he000_0000 | 32'(i);
            step();
        end
        load_data = 32'he000_0005;
        load_done = 1'b1;
        step();
        load_we = 1'b0;
        load_done = 1'b0;
        checks++;
        if (loading !== 1'b0 || load_count !== 9'd6) begin
            errors++;
            $display("FAIL we_done got l%b c%0d exp l0 c6",
                     loading, load_count);
        end
        fetch_req = 1'b1;
        fetch_addr = 32'h14;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instruction !== 32'he000_0005) begin
            errors++;
            $display("FAIL we_done_word got %h exp e0000005", instruction);
        end
    endtask

    task automatic test_start_priority();
        load_start = 1'b1;
        step();
        load_we = 1'b1;
        load_data = 32'h7777_0000;
        step();
        load_start = 1'b1;
        load_done = 1'b1;
        load_data = 32'h7777_0001;
        step();
        load_start = 1'b0;
        load_done = 1'b0;
        checks++;
        if (loading !== 1'b1 || load_count !== 9'd0) begin
            errors++;
            $display("FAIL start_prio got l%b c%0d exp l1 c0",
                     loading, load_count);
        end
        load_data = 32'h7777_0002;
        load_done = 1'b1;
        step();
        load_we = 1'b0;
        load_done = 1'b0;
        fetch_req = 1'b1;
        fetch_addr = 32'h0;
        step();
        fetch_addr = 32'h4;
        step();
        fetch_req = 1'b0;
        checks++;
        if (instruction !== 32'he000_0001 || load_count !== 9'd1) begin
            errors++;
            $display("FAIL start_prio_mem got %h c%0d exp e0000001 c1",
                     instruction, load_count);
        end
    endtask

    initial begin
        test_reset();
        test_load_fetch();
        test_fault();
        test_stall();
        test_overflow();
        test_reset_mid_load();
        test_we_done();
        test_start_priority();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
